// File: rtl/timer_pkg.sv
// Shared encodings and constants for the multi-channel timer/PWM generator.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_t;

  // Terminal count for a 1 s period at 50 MHz.
  localparam int unsigned SEC_END_50M = 50_000_000 - 1;

endpackage

// File: rtl/timer_pwm_ch.sv
// One timer/PWM channel: counter, active/shadow config, IDLE/RUN/HOLD FSM.
// Outputs are registered one cycle after the counter value; config writes are never stalled.
module timer_pwm_ch
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_END = 200_000_000 - 1,
  parameter int unsigned DEF_MD  = DEF_END / 2
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_end,
  input  logic [CNT_W-1:0] wr_md,
  input  logic             wr_oneshot,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] p_act, t_act, p_sh, t_sh;
  mode_t            m_act, m_sh, wr_mode, wrap_mode;
  logic             pend;
  logic             wrap;

  assign wr_mode = mode_t'(wr_oneshot);
  assign wrap    = (state == RUN) && en && (cnt == p_act);
  assign busy    = (state == RUN);

  // The one-shot decision at a wrap uses whichever mode becomes active there.
  always_comb begin
    wrap_mode = m_act;
    if (wr)
      wrap_mode = wr_mode;
    else if (pend)
      wrap_mode = m_sh;

    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en)
          state_nxt = IDLE;
        else if (wrap && (wrap_mode == MODE_ONESHOT))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (!en)
          state_nxt = IDLE;
        else if (wr)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state == RUN && en && !wrap) ? cnt + CNT_W'(1) : '0;
      pwm_out     <= (state == RUN) && (cnt >= t_act);
      period_tick <= wrap;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      p_act <= CNT_W'(DEF_END);
      t_act <= CNT_W'(DEF_MD);
      m_act <= MODE_CONT;
      p_sh  <= CNT_W'(DEF_END);
      t_sh  <= CNT_W'(DEF_MD);
      m_sh  <= MODE_CONT;
      pend  <= 1'b0;
    end else if (state != RUN || wrap) begin
      if (wr) begin
        p_act <= wr_end;
        t_act <= wr_md;
        m_act <= wr_mode;
        p_sh  <= wr_end;
        t_sh  <= wr_md;
        m_sh  <= wr_mode;
        pend  <= 1'b0;
      end else if (wrap && pend) begin
        p_act <= p_sh;
        t_act <= t_sh;
        m_act <= m_sh;
        pend  <= 1'b0;
      end
    end else if (wr) begin
      p_sh <= wr_end;
      t_sh <= wr_md;
      m_sh <= wr_mode;
      pend <= 1'b1;
    end
  end

endmodule

// File: rtl/timer_pwm_gen.sv
// Multi-channel timer/PWM generator; decodes cfg_wr by cfg_ch into CH_NUM channels.
// Optional sticky per-channel irq (set by period_tick, set beats clear) under TIMER_PWM_IRQ_EN.
module timer_pwm_gen
  import timer_pkg::*;
#(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_END = 200_000_000 - 1,
  parameter int unsigned DEF_MD  = DEF_END / 2
) (
  input  logic                                    sclk,
  input  logic                                    s_rst_n,
  input  logic [CH_NUM-1:0]                       ch_en,
  input  logic                                    cfg_wr,
  input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                        cfg_end,
  input  logic [CNT_W-1:0]                        cfg_md,
  input  logic                                    cfg_oneshot,
  output logic [CH_NUM-1:0]                       pwm_out,
  output logic [CH_NUM-1:0]                       period_tick,
  output logic [CH_NUM-1:0]                       busy
`ifdef TIMER_PWM_IRQ_EN
  ,
  input  logic [CH_NUM-1:0]                       irq_clr,
  output logic [CH_NUM-1:0]                       irq
`endif
);

  genvar i;
  generate
    for (i = 0; i < CH_NUM; i++) begin : g_ch
      timer_pwm_ch #(
        .CNT_W   (CNT_W),
        .DEF_END (DEF_END),
        .DEF_MD  (DEF_MD)
      ) u_ch (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .en          (ch_en[i]),
        .wr          (cfg_wr && (int'(cfg_ch) == i)),
        .wr_end      (cfg_end),
        .wr_md       (cfg_md),
        .wr_oneshot  (cfg_oneshot),
        .pwm_out     (pwm_out[i]),
        .period_tick (period_tick[i]),
        .busy        (busy[i])
      );
    end
  endgenerate

`ifdef TIMER_PWM_IRQ_EN
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n)
      irq <= '0;
    else
      irq <= (irq & ~irq_clr) | period_tick;
  end
`endif

endmodule
